// File: rtl/ram_link_pkg.sv
// Shared constants for the board-to-board ROM->RAM link receiver.
package ram_link_pkg;

  // Receiver FSM encoding
  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_LOST  = 2'd3;

  // Default link geometry
  localparam int AW_DEF = 4;
  localparam int DW_DEF = 4;

  // Compare-error counter saturates here
  localparam logic [3:0] ERR_CNT_MAX = 4'd15;

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchronizer for an asynchronous remote input.
module sync_bit #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] sr_q, sr_d;

  // Shift the raw input in at the bottom of the chain
  always_comb begin
    sr_d = {sr_q[N-2:0], i_d};
  end

  // Synchronizer chain, cleared to 0 on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign o_q = sr_q[N-1];

endmodule

// File: rtl/ram_fpga2_rx.sv
// Receive end of the ROM->RAM link: samples the remote strobe/bus, fills a
// small RAM during the write phase and checks it during the read phase.
module ram_fpga2_rx
  import ram_link_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 200_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_1hz,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] leds,
  output logic          o_wr_active,
  output logic          o_rd_active,
  output logic          o_mismatch,
  output logic [3:0]    o_err_cnt,
  output logic          o_link_lost
);

  localparam int DEPTH = 2 ** AW;
  localparam int WDW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);

  // ---------------- input synchronizers ----------------
  logic          strb_s, we_s;
  logic [AW-1:0] addr_s;
  logic [DW-1:0] data_s;

  sync_bit #(.N(SYNC_STAGES)) u_sync_strb (.clk(clk), .rst_n(rst_n), .i_d(i_1hz),   .o_q(strb_s));
  sync_bit #(.N(SYNC_STAGES)) u_sync_we   (.clk(clk), .rst_n(rst_n), .i_d(i_wr_en), .o_q(we_s));

  for (genvar a = 0; a < AW; a++) begin : g_sync_addr
    sync_bit #(.N(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .i_d(i_addr[a]), .o_q(addr_s[a]));
  end

  for (genvar d = 0; d < DW; d++) begin : g_sync_data
    sync_bit #(.N(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .i_d(i_data[d]), .o_q(data_s[d]));
  end

  // Strobe falling-edge detect; the remote bus is mid-period stable here
  logic strb_dly_q, strb_dly_d;
  logic fall;

  always_comb begin
    strb_dly_d = strb_s;
  end

  assign fall = strb_dly_q & ~strb_s;

  // ---------------- state and datapath registers ----------------
  logic [1:0]       state_q, state_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DW-1:0]    leds_q, leds_d;
  logic             mism_q, mism_d;
  logic [3:0]       err_q, err_d;
  logic [DW-1:0]    mem_q [DEPTH];

  logic             timeout;
  logic             do_write, do_read, new_frame;
  logic [DEPTH-1:0] addr_oh;
  logic [DW-1:0]    rd_data;
  logic             cmp_err;

  assign timeout = (wd_q == WD_LAST);
  assign addr_oh = DEPTH'(1) << addr_s;
  assign rd_data = mem_q[addr_s];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_WAIT;
    else        state_q <= state_d;
  end

  // FSM next state; a strobe edge wins over a same-cycle timeout
  always_comb begin
    state_d = state_q;
    if (fall) begin
      case (state_q)
        S_WAIT:  if (we_s)  state_d = S_WRITE;
        S_WRITE: if (!we_s) state_d = S_READ;
        S_READ:  if (we_s)  state_d = S_WRITE;
        default:            state_d = S_WAIT;
      endcase
    end else if (timeout && state_q != S_LOST) begin
      state_d = S_LOST;
    end
  end

  // FSM outputs: phase decodes plus per-sample datapath strobes
  always_comb begin
    o_wr_active = (state_q == S_WRITE);
    o_rd_active = (state_q == S_READ);
    o_link_lost = (state_q == S_LOST);
    do_write    = 1'b0;
    do_read     = 1'b0;
    new_frame   = 1'b0;
    if (fall) begin
      case (state_q)
        S_WAIT:  begin do_write = we_s; new_frame = we_s; end
        S_WRITE: begin do_write = we_s; do_read = ~we_s; end
        S_READ:  begin do_write = we_s; new_frame = we_s; do_read = ~we_s; end
        default: ;
      endcase
    end
  end

  // Only addresses written in this frame take part in the compare
  assign cmp_err = do_read & valid_q[addr_s] & (rd_data != data_s);

  // Next values for watchdog, valid map, LEDs and error flags
  always_comb begin
    wd_d    = wd_q;
    valid_d = valid_q;
    leds_d  = leds_q;
    mism_d  = mism_q;
    err_d   = err_q;

    if (fall)          wd_d = '0;
    else if (!timeout) wd_d = wd_q + 1'b1;

    if (new_frame)     valid_d = addr_oh;
    else if (do_write) valid_d = valid_q | addr_oh;

    if (do_write)      leds_d = data_s;
    else if (do_read)  leds_d = rd_data;

    if (cmp_err) begin
      mism_d = 1'b1;
      if (err_q != ERR_CNT_MAX) err_d = err_q + 4'd1;
    end
  end

  // Control and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_dly_q <= 1'b0;
      wd_q       <= '0;
      valid_q    <= '0;
      leds_q     <= '0;
      mism_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      strb_dly_q <= strb_dly_d;
      wd_q       <= wd_d;
      valid_q    <= valid_d;
      leds_q     <= leds_d;
      mism_q     <= mism_d;
      err_q      <= err_d;
    end
  end

  // RAM array; contents survive reset and link loss
  always_ff @(posedge clk) begin
    if (do_write) mem_q[addr_s] <= data_s;
  end

  assign leds       = leds_q;
  assign o_mismatch = mism_q;
  assign o_err_cnt  = err_q;

endmodule
